// File: rtl/rle_if.sv
// Sample/word bus between the sampler, the run-length encoder and the sample FIFO.
interface rle_if #(parameter int W = 8);
   logic [W-1:0] dataIn;
   logic         validIn;
   logic [W-1:0] dataOut;
   logic         validOut;

   modport master (output dataIn, output validIn, input dataOut, input validOut);
   modport slave  (input dataIn, input validIn, output dataOut, output validOut);
endinterface

// File: rtl/rle_encoder.sv
// Run-length encoder: value word {0,sample[W-2:0]} followed by count word {1,N}.
// With enable low it is a one-cycle registered pass-through.
module rle_encoder #(
   parameter int SAMPLE_WIDTH = 8
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   input  logic flush,
   output logic pending,
   rle_if.slave bus
);

   localparam int CW = SAMPLE_WIDTH - 1;
   localparam logic [CW-1:0] CMAX    = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

   logic [CW-1:0]           r_last;
   logic [CW-1:0]           r_cnt;
   logic                    r_first;
   logic                    r_flushPend;
   logic [SAMPLE_WIDTH-1:0] r_hold;
   logic                    r_holdValid;

   logic [CW-1:0]           w_x;
   logic [1:0]              w_nWords;
   logic [SAMPLE_WIDTH-1:0] w_word0;
   logic [SAMPLE_WIDTH-1:0] w_word1;
   logic [CW-1:0]           w_lastNext;
   logic [CW-1:0]           w_cntNext;
   logic                    w_firstNext;
   logic                    w_flushPendNext;

   // Words produced this cycle and the next run state; a flush that collides
   // with a sample is parked until the first idle cycle.
   always_comb begin
      w_x             = bus.dataIn[CW-1:0];
      w_nWords        = 2'd0;
      w_word0         = '0;
      w_word1         = '0;
      w_lastNext      = r_last;
      w_cntNext       = r_cnt;
      w_firstNext     = r_first;
      w_flushPendNext = r_flushPend;
      if (bus.validIn) begin
         if (r_first || (w_x != r_last && r_cnt == '0)) begin
            w_nWords    = 2'd1;
            w_word0     = {1'b0, w_x};
            w_lastNext  = w_x;
            w_cntNext   = '0;
            w_firstNext = 1'b0;
         end else if (w_x != r_last) begin
            w_nWords   = 2'd2;
            w_word0    = {1'b1, r_cnt};
            w_word1    = {1'b0, w_x};
            w_lastNext = w_x;
            w_cntNext  = '0;
         end else if (r_cnt + CNT_ONE != CMAX) begin
            w_cntNext = r_cnt + CNT_ONE;
         end else begin
            w_nWords    = 2'd1;
            w_word0     = {1'b1, CMAX};
            w_cntNext   = '0;
            w_firstNext = 1'b1;
         end
         if (flush) begin
            w_flushPendNext = 1'b1;
         end
      end else if (flush || r_flushPend) begin
         if (r_cnt != '0) begin
            w_nWords = 2'd1;
            w_word0  = {1'b1, r_cnt};
         end
         w_cntNext       = '0;
         w_firstNext     = 1'b1;
         w_flushPendNext = 1'b0;
      end
   end

   // Two-entry output queue: the hold word always drains first, and any word
   // generated in that same cycle takes its place in hold.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_last       <= '0;
         r_cnt        <= '0;
         r_first      <= 1'b1;
         r_flushPend  <= 1'b0;
         r_hold       <= '0;
         r_holdValid  <= 1'b0;
         bus.dataOut  <= '0;
         bus.validOut <= 1'b0;
      end else if (clear) begin
         r_cnt        <= '0;
         r_first      <= 1'b1;
         r_flushPend  <= 1'b0;
         r_holdValid  <= 1'b0;
         bus.validOut <= 1'b0;
      end else if (!enable) begin
         bus.dataOut  <= bus.dataIn;
         bus.validOut <= bus.validIn;
      end else begin
         r_last      <= w_lastNext;
         r_cnt       <= w_cntNext;
         r_first     <= w_firstNext;
         r_flushPend <= w_flushPendNext;
         if (r_holdValid) begin
            bus.dataOut  <= r_hold;
            bus.validOut <= 1'b1;
            r_hold       <= w_word0;
            r_holdValid  <= (w_nWords != 2'd0);
         end else if (w_nWords != 2'd0) begin
            bus.dataOut  <= w_word0;
            bus.validOut <= 1'b1;
            r_hold       <= w_word1;
            r_holdValid  <= (w_nWords == 2'd2);
         end else begin
            bus.validOut <= 1'b0;
         end
      end
   end

   assign pending = (r_cnt != '0) || r_flushPend || r_holdValid;

endmodule

// File: tb/tb_rle_encoder.sv
// Scoreboard bench for rle_encoder: a run-based reference model queues expected
// words with their due cycle; a negedge monitor pops and compares them.
module tb_rle_encoder;

   localparam int W    = 8;
   localparam int CMAX = 127;

   logic clock   = 1'b0;
   logic reset   = 1'b1;
   logic enable  = 1'b0;
   logic clear   = 1'b0;
   logic flush   = 1'b0;
   logic pending;

   rle_if #(.W(W)) bus ();

   rle_encoder #(.SAMPLE_WIDTH(W)) dut (
      .clock   (clock),
      .reset   (reset),
      .enable  (enable),
      .clear   (clear),
      .flush   (flush),
      .pending (pending),
      .bus     (bus.slave)
   );

   always #5 clock = ~clock;

   int edgeCount = 0;
   always @(posedge clock) edgeCount <= edgeCount + 1;

   typedef struct {
      logic [7:0] word;
      int         due;
   } exp_t;

   exp_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;

   // Reference model: a run is a value plus how many samples it has absorbed.
   int mRunVal    = 0;
   int mRunLen    = 0;
   bit mFlushPend = 1'b0;
   int mLastDue   = 0;

   // Output port takes one word per cycle, so each word is due no earlier than
   // its own latency and no earlier than the cycle after the previous word.
   function automatic void pushWord(input int w, input int desired);
      exp_t e;
      e.word   = 8'(w);
      e.due    = (desired > mLastDue + 1) ? desired : mLastDue + 1;
      mLastDue = e.due;
      sb.push_back(e);
   endfunction

   function automatic void modelReset();
      sb.delete();
      mRunLen    = 0;
      mFlushPend = 1'b0;
      mLastDue   = 0;
   endfunction

   function automatic void modelStep(input bit en, input bit clr, input bit fl,
                                     input bit vld, input int d, input int e);
      int x;
      int k;
      x = d & 'h7f;
      k = 0;
      if (clr) begin
         while (sb.size() > 0 && sb[$].due >= e) void'(sb.pop_back());
         mRunLen    = 0;
         mFlushPend = 1'b0;
         mLastDue   = e;
      end else if (!en) begin
         if (vld) pushWord(d, e);
      end else if (vld) begin
         if (mRunLen == 0) begin
            pushWord(x, e);
            mRunVal = x;
            mRunLen = 1;
         end else if (x != mRunVal) begin
            if (mRunLen > 1) begin
               pushWord('h80 | (mRunLen - 1), e);
               k = 1;
            end
            pushWord(x, e + k);
            mRunVal = x;
            mRunLen = 1;
         end else begin
            mRunLen++;
            if (mRunLen == CMAX + 1) begin
               pushWord('h80 | CMAX, e);
               mRunLen = 0;
            end
         end
         if (fl) mFlushPend = 1'b1;
      end else if (fl || mFlushPend) begin
         if (mRunLen > 1) pushWord('h80 | (mRunLen - 1), e);
         mRunLen    = 0;
         mFlushPend = 1'b0;
      end
   endfunction

   // Drive one cycle of inputs just after the falling edge and let the model
   // predict what the coming rising edge produces.
   task automatic applyStimulus(input bit en, input bit clr, input bit fl,
                                input bit vld, input int d);
      @(negedge clock);
      #1;
      enable      = en;
      clear       = clr;
      flush       = fl;
      bus.validIn = vld;
      bus.dataIn  = 8'(d);
      modelStep(en, clr, fl, vld, d, edgeCount + 1);
      #1;
      compared++;
      if (dut.r_holdValid && dut.w_nWords == 2'd2) begin
         mismatched++;
         $display("[TB] FAIL holdOverflow: hold occupied with two-word event at edge %0d", edgeCount + 1);
      end
   endtask

   task automatic idle(input bit en, input int n);
      for (int i = 0; i < n; i++) applyStimulus(en, 1'b0, 1'b0, 1'b0, 0);
   endtask

   task automatic run(input int d, input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, d);
   endtask

   task automatic checkReset(input string tag);
      compared += 3;
      if (bus.dataOut !== 8'h00) begin
         mismatched++;
         $display("[TB] FAIL %s dataOut: got %h expected 00", tag, bus.dataOut);
      end
      if (bus.validOut !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL %s validOut: got %b expected 0", tag, bus.validOut);
      end
      if (pending !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL %s pending: got %b expected 0", tag, pending);
      end
   endtask

   task automatic doReset();
      @(negedge clock);
      #1;
      reset       = 1'b1;
      bus.validIn = 1'b0;
      flush       = 1'b0;
      clear       = 1'b0;
      modelReset();
      #1;
      checkReset("midReset");
      @(negedge clock);
      #1;
      reset = 1'b0;
   endtask

   // Monitor: compare whatever the DUT presents against the scoreboard head.
   task automatic checkOutput();
      bit   expPending;
      exp_t e;
      expPending = (mRunLen > 1) || mFlushPend;
      foreach (sb[i]) if (sb[i].due > edgeCount) expPending = 1'b1;
      compared++;
      if (pending !== expPending) begin
         mismatched++;
         $display("[TB] FAIL pending@%0d: got %b expected %b", edgeCount, pending, expPending);
      end
      if (bus.validOut === 1'b1) begin
         compared++;
         if (sb.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL unexpectedWord@%0d: got %h expected no word", edgeCount, bus.dataOut);
         end else begin
            e = sb.pop_front();
            if (bus.dataOut !== e.word || e.due != edgeCount) begin
               mismatched++;
               $display("[TB] FAIL word: got %h at edge %0d expected %h at edge %0d",
                        bus.dataOut, edgeCount, e.word, e.due);
            end
         end
      end else if (sb.size() > 0 && sb[0].due <= edgeCount) begin
         compared++;
         mismatched++;
         e = sb.pop_front();
         $display("[TB] FAIL missingWord@%0d: got validOut=%b expected %h due at edge %0d",
                  edgeCount, bus.validOut, e.word, e.due);
      end
   endtask

   always @(negedge clock) begin
      if (!reset) checkOutput();
   end

   int prevVal;
   int pick;

   initial begin
      bus.validIn = 1'b0;
      bus.dataIn  = '0;
      @(negedge clock);
      #1;
      checkReset("reset");
      @(negedge clock);
      #1;
      reset = 1'b0;

      $display("[TB] pass-through");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 'hA5);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 'h5A);
      idle(1'b0, 3);

      $display("[TB] basic run");
      idle(1'b1, 1);
      run('h05, 4);
      run('h09, 1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 0);
      idle(1'b1, 3);

      $display("[TB] saturation");
      run('h11, 130);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 0);
      idle(1'b1, 3);

      $display("[TB] alternating with bit 7 set");
      run('h81, 1);
      run('h02, 1);
      run('h81, 1);
      run('h02, 1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 0);
      idle(1'b1, 3);

      $display("[TB] flush collision");
      run('h33, 3);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 'h33);
      idle(1'b1, 3);

      $display("[TB] clear mid-run");
      run('h55, 11);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 'h55);
      idle(1'b1, 3);
      run('h44, 1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 0);
      idle(1'b1, 2);
      run('h20, 2);
      run('h21, 1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0);
      idle(1'b1, 3);
      run('h44, 1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 0);
      idle(1'b1, 2);

      $display("[TB] reset mid-run");
      run('h66, 11);
      doReset();
      idle(1'b1, 2);
      run('h44, 1);
      run('h66, 3);
      run('h67, 1);
      doReset();
      idle(1'b1, 2);
      run('h44, 1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 0);
      idle(1'b1, 3);

      $display("[TB] randomized RLE traffic");
      prevVal = 'h01;
      for (int i = 0; i < 900; i++) begin
         if ($urandom_range(3, 0) != 0) begin
            pick = $urandom_range(4, 0);
            if ($urandom_range(3, 0) == 0)
               prevVal = (pick == 0) ? 'h01 : (pick == 1) ? 'h81 : (pick == 2) ? 'h7F :
                         (pick == 3) ? 'h00 : 'hC2;
            applyStimulus(1'b1, ($urandom_range(149, 0) == 0), ($urandom_range(24, 0) == 0),
                          1'b1, prevVal);
         end else begin
            applyStimulus(1'b1, ($urandom_range(149, 0) == 0), ($urandom_range(9, 0) == 0),
                          1'b0, 0);
         end
         if (i == 400) run('h3C, 300);
      end
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 0);
      idle(1'b1, 4);

      $display("[TB] randomized pass-through");
      for (int i = 0; i < 40; i++)
         applyStimulus(1'b0, 1'b0, 1'b0, ($urandom_range(1, 0) == 1), $urandom_range(255, 0));
      idle(1'b0, 2);

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
      compared++;
      if (sb.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL drain: got %0d words outstanding expected 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
